instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Upstream feeder for the 12-bit CPU instruction input. Holds a small program RAM loaded over a write port.
//  On Start, emits one stored instruction word per clock from address 0 upward; stalls on Hold; stops or loops at program end.
//  Instr drives the CPU's 12-bit input directly: Instr[11:8] = opcode, Instr[7:0] = 8-bit operand.
// PARAMETERS
//  DEPTH     16       program RAM entries (power of two)
//  AW        4        address width, log2(DEPTH)
//  NOP_WORD  12'h000  word driven on Instr whenever no instruction is issued
// PORTS
//  Clk         in   1     rising-edge clock
//  Rst_n       in   1     synchronous active-low reset
//  Load_En     in   1     write Load_Data to RAM[Load_Addr]; honoured only in IDLE
//  Load_Addr   in   AW    RAM write address
//  Load_Data   in   12    RAM write data
//  Prog_Len    in   AW+1  number of words to run; sampled on Start; values >DEPTH clamp to DEPTH
//  Loop        in   1     1: wrap to address 0 after last word; sampled on Start
//  Start       in   1     begin run; honoured only in IDLE with Prog_Len != 0
//  Hold        in   1     stall issue for this cycle (RUN only)
//  Abort       in   1     stop run, return to IDLE
//  Instr       out  12    instruction word to the CPU (registered)
//  Instr_Valid out  1     Instr carries a program word this cycle
//  Pc          out  AW    address of next word to fetch
//  Busy        out  1     state == RUN
//  Done        out  1     one-cycle pulse, concurrent with the last issued word of a non-loop run
// BEHAVIOUR
//  Reset (Rst_n=0 at an edge): state=IDLE, Pc=0, Instr=NOP_WORD, Instr_Valid=0, Done=0, latched len/loop=0.
//   RAM contents not reset. Reset mid-run aborts at once, with no Done.
//  FSM states: IDLE, RUN. All outputs registered.
//  IDLE:
//   - Load_En: RAM write at the edge.
//   - Start & len!=0: latch min(Prog_Len,DEPTH) and Loop, Pc<=0, ->RUN.
//   - Instr=NOP_WORD, Valid=0.
//  RUN, each edge, priority Abort > Hold > issue:
//   - Abort: ->IDLE, Pc<=0, Instr<=NOP_WORD, Valid<=0, Done<=0.
//   - Hold: Instr<=NOP_WORD, Valid<=0, Pc unchanged.
//   - issue: Instr<=RAM[Pc], Valid<=1.
//     - Pc != len-1: Pc<=Pc+1.
//     - Pc == len-1 & Loop: Pc<=0, stay RUN.
//     - Pc == len-1 & !Loop: Pc<=0, ->IDLE, Done<=1.
//  Done and Valid fall at the following edge, when Instr returns to NOP_WORD.
//  Latency: Start accepted at edge k; RAM[0] appears on Instr after edge k+1. One word per unstalled cycle.
//  Load_En, Start and Prog_Len changes are ignored in RUN; the run uses the latched length.
//  Load and Start in the same IDLE edge: write completes first; fetch at k+1 sees the new data.
//  len == DEPTH: Pc wraps naturally from DEPTH-1 to 0. len == 1 with Loop: RAM[0] every unstalled cycle.
//  Start and Abort together in IDLE: Start wins, since Abort has no effect in IDLE.
// TESTING
//  T1 load RAM[0..2]=12'h1A5,12'h2B6,12'h3C7; Prog_Len=3, Loop=0, Start
//     -> Instr 1A5,2B6,3C7 on consecutive cycles; Valid=1 for those cycles;
//        Done=1 with 3C7; then Instr=000, Busy=0.
//  T2 as T1, Hold=1 for one cycle after the first word
//     -> 1A5,000(Valid=0),2B6,3C7; Pc holds 1 during the stall.
//  T3 Prog_Len=2, Loop=1, Start; run 6 cycles
//     -> 1A5,2B6,1A5,2B6,1A5,2B6; Done never asserts; Abort -> Instr=000, Busy=0 next edge.
//  T4 Rst_n=0 for one edge mid-run -> Instr=000, Valid=0, Pc=0, Busy=0, no Done;
//     RAM still reads 1A5 on the next run.
//  T5 Start with Prog_Len=0 -> stays IDLE. Load_En during RUN -> RAM unchanged.
//     Prog_Len=31 with DEPTH=16 -> 16 words issued, then Done.

Source files
------------

// File: rtl/instr_sequencer.sv
// Program-RAM instruction feeder for the 12-bit CPU input: loads words in IDLE,
// then streams RAM[0..len-1] one word per unstalled cycle, optionally looping.
module instr_sequencer #(
    parameter int          DEPTH    = 16,
    parameter int          AW       = 4,
    parameter logic [11:0] NOP_WORD = 12'h000
) (
    input  logic          Clk_i,
    input  logic          Rst_n_i,
    input  logic          Load_En_i,
    input  logic [AW-1:0] Load_Addr_i,
    input  logic [11:0]   Load_Data_i,
    input  logic [AW:0]   Prog_Len_i,
    input  logic          Loop_i,
    input  logic          Start_i,
    input  logic          Hold_i,
    input  logic          Abort_i,
    output logic [11:0]   Instr_o,
    output logic          Instr_Valid_o,
    output logic [AW-1:0] Pc_o,
    output logic          Busy_o,
    output logic          Done_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } stateT;

    localparam logic [AW:0] DepthLen = (AW+1)'(DEPTH);

    stateT          state_q;
    logic [11:0]    ram_q [DEPTH];
    logic [AW-1:0]  pc_q;
    logic [AW:0]    len_q;
    logic           loop_q;
    logic [11:0]    instr_q;
    logic           valid_q;
    logic           done_q;

    logic [AW:0]    len_d;
    logic           lastWord_d;

    always_comb begin
        len_d      = (Prog_Len_i > DepthLen) ? DepthLen : Prog_Len_i;
        lastWord_d = ({1'b0, pc_q} == (len_q - 1'b1));
    end

    // Program RAM has no reset; writes are accepted only while idle and out of reset.
    always_ff @(posedge Clk_i) begin
        if (Rst_n_i && (state_q == IDLE) && Load_En_i) begin
            ram_q[Load_Addr_i] <= Load_Data_i;
        end
    end

    always_ff @(posedge Clk_i) begin
        if (!Rst_n_i) begin
            state_q <= IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    instr_q <= NOP_WORD;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    if (Start_i && (Prog_Len_i != '0)) begin
                        len_q   <= len_d;
                        loop_q  <= Loop_i;
                        pc_q    <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (Abort_i) begin
                        state_q <= IDLE;
                        pc_q    <= '0;
                        instr_q <= NOP_WORD;
                        valid_q <= 1'b0;
                        done_q  <= 1'b0;
                    end else if (Hold_i) begin
                        instr_q <= NOP_WORD;
                        valid_q <= 1'b0;
                        done_q  <= 1'b0;
                    end else begin
                        instr_q <= ram_q[pc_q];
                        valid_q <= 1'b1;
                        // On the last word the run either wraps or finishes with a Done pulse.
                        if (lastWord_d) begin
                            pc_q <= '0;
                            if (!loop_q) begin
                                state_q <= IDLE;
                                done_q  <= 1'b1;
                            end else begin
                                done_q  <= 1'b0;
                            end
                        end else begin
                            pc_q   <= pc_q + 1'b1;
                            done_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    pc_q    <= '0;
                    instr_q <= NOP_WORD;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Instr_o       = instr_q;
    assign Instr_Valid_o = valid_q;
    assign Pc_o          = pc_q;
    assign Busy_o        = (state_q == RUN);
    assign Done_o        = done_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: directed scenarios then random traffic,
// predicted by a program-level model and checked by an independent monitor.
module tb_instr_sequencer;

    localparam int          DEPTH = 16;
    localparam int          AW    = 4;
    localparam logic [11:0] NOP   = 12'h000;

    logic          clock = 1'b0;
    logic          rstN;
    logic          loadEn;
    logic [AW-1:0] loadAddr;
    logic [11:0]   loadData;
    logic [AW:0]   progLen;
    logic          loopIn;
    logic          startIn;
    logic          holdIn;
    logic          abortIn;
    logic [11:0]   instr;
    logic          instrValid;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;

    always #5 clock = ~clock;

    instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .NOP_WORD(NOP)) dut (
        .Clk_i         (clock),
        .Rst_n_i       (rstN),
        .Load_En_i     (loadEn),
        .Load_Addr_i   (loadAddr),
        .Load_Data_i   (loadData),
        .Prog_Len_i    (progLen),
        .Loop_i        (loopIn),
        .Start_i       (startIn),
        .Hold_i        (holdIn),
        .Abort_i       (abortIn),
        .Instr_o       (instr),
        .Instr_Valid_o (instrValid),
        .Pc_o          (pc),
        .Busy_o        (busy),
        .Done_o        (done)
    );

    typedef struct {
        int          cyc;
        logic [11:0] word;
        logic        isLast;
    } wordT;

    typedef struct {
        logic          isBusy;
        logic [AW-1:0] nextPc;
    } statusT;

    wordT   wordQ[$];
    statusT statusQ[$];

    int edgeCount  = 0;
    int checkCount = 0;
    int passCount  = 0;

    // Program-level model: what is stored, whether a run is active, and where it is.
    logic [11:0] modelRam [DEPTH];
    bit          modelBusy = 1'b0;
    bit          modelLoop = 1'b0;
    int          modelLen  = 0;
    int          modelPc   = 0;

    always @(posedge clock) edgeCount <= edgeCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, actual, expected, edgeCount);
    endtask

    // Drive one cycle of inputs, predict the effect of the coming edge, then wait for it.
    task automatic applyStimulus(input bit r, input bit ld, input int la, input int ldata,
                                 input int plen, input bit lp, input bit st, input bit hd, input bit ab);
        wordT   w;
        statusT s;
        rstN     = r;
        loadEn   = ld;
        loadAddr = AW'(la);
        loadData = 12'(ldata);
        progLen  = (AW+1)'(plen);
        loopIn   = lp;
        startIn  = st;
        holdIn   = hd;
        abortIn  = ab;
        if (!r) begin
            modelBusy = 1'b0;
            modelPc   = 0;
        end else if (!modelBusy) begin
            if (ld) modelRam[la] = 12'(ldata);
            if (st && plen != 0) begin
                modelBusy = 1'b1;
                modelLen  = (plen > DEPTH) ? DEPTH : plen;
                modelLoop = lp;
                modelPc   = 0;
            end
        end else if (ab) begin
            modelBusy = 1'b0;
            modelPc   = 0;
        end else if (!hd) begin
            w.cyc    = edgeCount + 1;
            w.word   = modelRam[modelPc];
            w.isLast = (modelPc == modelLen - 1) && !modelLoop;
            wordQ.push_back(w);
            if (modelPc == modelLen - 1) begin
                modelPc = 0;
                if (!modelLoop) modelBusy = 1'b0;
            end else begin
                modelPc = modelPc + 1;
            end
        end
        s.isBusy = modelBusy;
        s.nextPc = AW'(modelPc);
        statusQ.push_back(s);
        @(posedge clock);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: pops a word whenever the DUT presents one, and a status entry every cycle.
    always @(negedge clock) begin : monitor
        wordT   w;
        statusT s;
        if (statusQ.size() > 0) begin
            s = statusQ.pop_front();
            checkOutput("busy", 32'(busy), 32'(s.isBusy));
            checkOutput("pc", 32'(pc), 32'(s.nextPc));
        end
        if (instrValid === 1'b1) begin
            if (wordQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpected word: got %0h, expected no valid word (edge %0d)", instr, edgeCount);
            end else begin
                w = wordQ.pop_front();
                checkOutput("word timing", 32'(edgeCount), 32'(w.cyc));
                checkOutput("instr", 32'(instr), 32'(w.word));
                checkOutput("done", 32'(done), 32'(w.isLast));
            end
        end else begin
            checkOutput("nop instr", 32'(instr), 32'(NOP));
            checkOutput("idle done", 32'(done), 32'(1'b0));
            checkOutput("valid", 32'(instrValid), 32'(1'b0));
        end
    end

    initial begin
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 'h1A5, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 'h2B6, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 2, 'h3C7, 0, 0, 0, 0, 0);

        // Plain three-word run
        applyStimulus(1, 0, 0, 0, 3, 0, 1, 0, 0);
        idleCycles(5);

        // One stall after the first word
        applyStimulus(1, 0, 0, 0, 3, 0, 1, 0, 0);
        idleCycles(1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0);
        idleCycles(4);

        // Looping two-word run, then abort
        applyStimulus(1, 0, 0, 0, 2, 1, 1, 0, 0);
        idleCycles(6);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
        idleCycles(2);

        // Reset mid-run, then rerun to confirm RAM survived
        applyStimulus(1, 0, 0, 0, 3, 0, 1, 0, 0);
        idleCycles(1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 3, 0, 1, 0, 0);
        idleCycles(4);

        // Zero length start, full RAM load, clamped length with a load attempt mid-run
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0);
        idleCycles(2);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, 1, i, $urandom_range(1, 4095), 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 31, 0, 1, 0, 0);
        applyStimulus(1, 1, 0, 'hFFF, 0, 0, 0, 0, 0);
        idleCycles(18);

        // Load and start on the same edge; single-word loop
        applyStimulus(1, 1, 0, 'hABC, 1, 0, 1, 0, 0);
        idleCycles(2);
        applyStimulus(1, 0, 0, 0, 1, 1, 1, 0, 0);
        idleCycles(4);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
        idleCycles(2);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            applyStimulus($urandom_range(0, 63) != 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, DEPTH - 1),
                          $urandom_range(0, 4095),
                          $urandom_range(0, 31),
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 5) == 0,
                          $urandom_range(0, 4) == 0,
                          $urandom_range(0, 19) == 0);
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
        idleCycles(3);
        @(negedge clock);
        #1;
        checkOutput("scoreboard drained", 32'(wordQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
